nibble_serial_add_ctrl: RTL and testbench
=========================================

Name: nibble_serial_add_ctrl

Overview:
Multi-cycle sequencer that performs WIDTH = 4*NIBBLES-bit add/subtract using one shared 4-bit carry-lookahead adder, one nibble per clock, LSB nibble first. The carry is registered between nibbles.
Sits between the operand-entry front end (buttons/debounce) and the seven-segment result path, and extends the 4-bit adder to wider words without replicating it.
Valid/ready handshakes on both the command side and the result side.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand (legal 1..8); WIDTH = 4*NIBBLES.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
start_valid  in  1  command present
start_ready  out  1  controller can accept a command
op_a  in  WIDTH  operand A, unsigned or two's complement
op_b  in  WIDTH  operand B
cin  in  1  carry-in for add; ignored when sub=1
sub  in  1  1 = A - B (B inverted, carry-in forced 1)
res_valid  out  1  result registers hold a completed result
res_ready  in  1  consumer accepts result
result  out  WIDTH  sum/difference
cout  out  1  carry out of MSB nibble (sub: 1 = no borrow)
overflow  out  1  signed overflow
busy  out  1  high in RUN and DONE

Behaviour:
- Reset (async, rst=1): state=IDLE, nibble index=0, carry reg=0, operand regs=0, result=0, cout=0, overflow=0, res_valid=0, busy=0, start_ready=0 while rst=1 and 1 from the first clock edge after release.
- States: IDLE, RUN, DONE.
- IDLE: start_ready=1. On start_valid at edge k:
  - latch op_a
  - latch op_b XOR {WIDTH{sub}}
  - carry reg = sub ? 1 : cin
  - clear result
  - idx=0; go to RUN.
- RUN: start_ready=0, busy=1. Each cycle the adder gets A[idx], B'[idx] and the carry reg.
  - The adder sum is written to result[4*idx+3:4*idx]; its cout is written to the carry reg.
  - idx increments.
  - When idx==NIBBLES-1, the edge writes cout and overflow and moves to DONE.
  - Latency: res_valid rises at edge k+NIBBLES; first sampled high in the cycle after edge k+NIBBLES.
- overflow = (a_msb == b'_msb) && (sum_msb != a_msb), using the latched (post-inversion) B.
- DONE: res_valid=1. result/cout/overflow are held stable until res_ready=1. On res_valid&&res_ready: res_valid=0, go to IDLE. result/cout/overflow keep their values until the next command is accepted.
- start_valid outside IDLE is ignored (no queueing). The requester must hold its command until start_ready.
- Operand inputs are sampled only at the accept edge. Changes during RUN have no effect.
- res_ready while not DONE has no effect.
- NIBBLES=1: RUN lasts one cycle; same rules apply.
- Reset mid-RUN or mid-DONE: immediate abort to reset values. No partial result is ever flagged valid.
- Adder path is combinational within the cycle; there is one register stage per nibble and no multicycle paths.

Decomposition:
- Shared package holds:
  - state enum (IDLE=2'b00, RUN=2'b01, DONE=2'b10)
  - NIBBLE_W=4 constant
  - index width function (clog2 of NIBBLES, minimum 1)
- One sub-module is natural: cla_add_4bit. It is the 4-bit lookahead adder slice (a, b, cin -> s, cout) and is instantiated once inside this controller.
- The nibble mux and demux, handshake logic and FSM stay in the top.

Test Plan:
1. NIBBLES=4, add 0x1234 + 0x0FFF, cin=0.
   -> result=0x2233, cout=0, overflow=0; res_valid first high 4 edges after accept.
2. Add 0xFFFF + 0x0001, cin=0 -> result=0x0000, cout=1, overflow=0.
   Add 0x7FFF + 0x0001 -> result=0x8000, cout=0, overflow=1.
3. sub=1: 0x0005 - 0x0007 -> result=0xFFFE, cout=0 (borrow), overflow=0.
   sub=1: 0x8000 - 0x0001 -> result=0x7FFF, overflow=1.
4. Backpressure: hold res_ready=0 for 3 cycles in DONE.
   -> result/res_valid stable, start_ready=0, a start_valid pulse is ignored.
   Raise res_ready -> IDLE next edge, start_ready=1.
5. Reset mid-op: assert rst 2 cycles after accept.
   -> all outputs 0 immediately, res_valid never pulses. After release, 0x00FF + 0x0001 cin=1 -> 0x0101.
6. Back-to-back commands with start_valid held high.
   -> second command accepted the cycle after the first handshake completes; results correct in order.

Source files
------------

// File: rtl/nibble_serial_add_ctrl_pkg.sv
// nibble_serial_add_ctrl_pkg: shared states, nibble width and index-width helper
package nibble_serial_add_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;
  localparam int NIBBLE_W = 4;
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/nibble_serial_add_ctrl_cla.sv
// cla_add_4bit: 4-bit carry-lookahead adder slice
module cla_add_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [3:0] g, p;
  logic [4:0] c;
  always_comb begin
    g = a & b;
    p = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    s = p ^ c[3:0];
    cout = c[4];
  end
endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: serial add/subtract, one nibble per clock through a shared 4-bit CLA
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4,
  localparam int WIDTH = 4 * NIBBLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  input  logic             sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);
  localparam int IW = idx_w(NIBBLES);
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, sr_q, sr_d;
  logic [3:0] a_nib, b_nib, sum;
  logic c_out;
  assign a_nib = a_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];
  assign b_nib = b_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];
  cla_add_4bit u_cla (.a(a_nib), .b(b_nib), .cin(carry_q), .s(sum), .cout(c_out));
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    a_d = a_q;
    b_d = b_q;
    res_d = res_q;
    carry_d = carry_q;
    cout_d = cout_q;
    ovf_d = ovf_q;
    sr_d = sr_q;
    if (state_q == IDLE) begin
      sr_d = 1'b1;
      if (start_valid && sr_q) begin
        a_d = op_a;
        b_d = op_b ^ {WIDTH{sub}};
        carry_d = sub | cin;
        res_d = '0;
        idx_d = '0;
        sr_d = 1'b0;
        state_d = RUN;
      end
    end else if (state_q == RUN) begin
      res_d[NIBBLE_W*int'(idx_q) +: NIBBLE_W] = sum;
      carry_d = c_out;
      idx_d = idx_q + 1'b1;
      if (idx_q == IW'(NIBBLES - 1)) begin
        cout_d = c_out;
        ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[3] != a_q[WIDTH-1]);
        idx_d = '0;
        state_d = DONE;
      end
    end else if (state_q == DONE) begin
      state_d = res_ready ? IDLE : DONE;
      sr_d = res_ready;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      carry_q <= 1'b0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
      sr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
      carry_q <= carry_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
      sr_q <= sr_d;
    end
  end
  assign start_ready = sr_q;
  assign res_valid = (state_q == DONE);
  assign busy = (state_q != IDLE);
  assign result = res_q;
  assign cout = cout_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: directed self-checking bench for the 16-bit configuration
module tb_nibble_serial_add_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic start_valid = 1'b0, start_ready, cin = 1'b0, sub = 1'b0;
  logic res_valid, res_ready = 1'b0, cout, overflow, busy;
  logic [15:0] op_a = '0, op_b = '0, result;
  int checks = 0, errors = 0;

  nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin), .sub(sub), .res_valid(res_valid),
    .res_ready(res_ready), .result(result), .cout(cout), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic sb, input logic [15:0] er,
                       input logic ec, input logic eo);
    start_valid = 1'b1; op_a = a; op_b = b; cin = ci; sub = sb;
    @(negedge clk);
    start_valid = 1'b0; op_a = 16'hdead; op_b = 16'hbeef; cin = ~ci; sub = ~sb;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_sready"}, start_ready, 0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check({tag, "_early_valid"}, res_valid, 0);
    end
    @(negedge clk);
    check({tag, "_valid"}, res_valid, 1);
    check({tag, "_result"}, result, er);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_ovf"}, overflow, eo);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_valid_drop"}, res_valid, 0);
    check({tag, "_sready_back"}, start_ready, 1);
    check({tag, "_hold_result"}, result, er);
  endtask

  initial begin
    @(negedge clk);
    check("rst_sready", start_ready, 0);
    check("rst_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_sready", start_ready, 1);

    do_op("add1", 16'h1234, 16'h0FFF, 0, 0, 16'h2233, 0, 0);
    do_op("add_wrap", 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0);
    do_op("add_ovf", 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1);
    do_op("add_cin", 16'h0010, 16'h0020, 1, 0, 16'h0031, 0, 0);
    do_op("sub_borrow", 16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0);
    do_op("sub_ovf", 16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1);

    // backpressure in DONE with an ignored start pulse
    start_valid = 1'b1; op_a = 16'h0001; op_b = 16'h0002; cin = 0; sub = 0;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      start_valid = (i == 1); op_a = 16'h5555; op_b = 16'h1111;
      check("bp_valid", res_valid, 1);
      check("bp_result", result, 16'h0003);
      check("bp_sready", start_ready, 0);
      check("bp_busy", busy, 1);
      @(negedge clk);
    end
    start_valid = 1'b0;
    check("bp_still_valid", res_valid, 1);
    check("bp_still_result", result, 16'h0003);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("bp_release_valid", res_valid, 0);
    check("bp_release_sready", start_ready, 1);
    check("bp_release_busy", busy, 0);
    check("bp_release_result", result, 16'h0003);

    // reset two cycles after accept
    start_valid = 1'b1; op_a = 16'h1111; op_b = 16'h1111;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_sready", start_ready, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_cout", cout, 0);
    check("mid_rst_ovf", overflow, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_rst_valid", res_valid, 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_valid", res_valid, 0);
    end
    check("post_rst2_sready", start_ready, 1);
    do_op("after_rst", 16'h00FF, 16'h0001, 1, 0, 16'h0101, 0, 0);

    // back-to-back with start_valid and res_ready held high
    start_valid = 1'b1; res_ready = 1'b1; op_a = 16'h1111; op_b = 16'h2222; cin = 0; sub = 0;
    @(negedge clk);
    op_a = 16'h4000; op_b = 16'h0001; sub = 1'b1;
    check("b2b_first_accept", start_ready, 0);
    repeat (3) @(negedge clk);
    check("b2b_first_early", res_valid, 0);
    @(negedge clk);
    check("b2b_first_valid", res_valid, 1);
    check("b2b_first_result", result, 16'h3333);
    @(negedge clk);
    check("b2b_idle_valid", res_valid, 0);
    check("b2b_idle_sready", start_ready, 1);
    @(negedge clk);
    start_valid = 1'b0;
    check("b2b_second_accept", start_ready, 0);
    check("b2b_second_busy", busy, 1);
    repeat (3) @(negedge clk);
    check("b2b_second_early", res_valid, 0);
    @(negedge clk);
    check("b2b_second_valid", res_valid, 1);
    check("b2b_second_result", result, 16'h3FFF);
    check("b2b_second_cout", cout, 1);
    check("b2b_second_ovf", overflow, 0);
    @(negedge clk);
    res_ready = 1'b0;
    check("b2b_end_valid", res_valid, 0);
    check("b2b_end_sready", start_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
